mult_arbiter: RTL



---
 rtl/mult_arb_pkg.sv | 22 ++
 rtl/mult_arbiter_rr_picker.sv | 34 +++
 rtl/mult_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mult_arb_pkg.sv
// Shared constants for the multiplier arbiter: data width, FSM encoding, index sizing.
// Latency: n/a (package only).
// Backpressure: n/a. BYPASS encoding exists only under MULT_ARB_ZERO_BYPASS_EN.
package mult_arb_pkg;

  localparam int DATA_W = 16;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
`ifdef MULT_ARB_ZERO_BYPASS_EN
  localparam logic [1:0] ST_BYPASS = 2'd2;
`endif

  // Bits needed to hold values 0..n-1 (minimum 1 bit so 1-entry ranges stay legal).
  function automatic int idx_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/mult_arbiter_rr_picker.sv
// Round-robin picker: first set request at or after ptr_i, searching upward with wrap.
// Latency: combinational.
// Backpressure: none; any_o low when nothing is requesting.
module rr_picker
  import mult_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  onehot_o,
  output logic [PW-1:0] idx_o,
  output logic          any_o
);

  // Walk the requests starting at the pointer; the first hit wins.
  always_comb begin
    int j;
    j        = 0;
    onehot_o = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr_i) + i) % N;
      if (!any_o && req_i[j]) begin
        any_o       = 1'b1;
        onehot_o[j] = 1'b1;
        idx_o       = PW'(j);
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one external 16-bit multiplier among NUM_REQ requesters.
// Latency: grant at E0, rsp_valid at E0+MULT_LATENCY+1 (one edge with MULT_ARB_ZERO_BYPASS_EN and a zero operand).
// Backpressure: one transaction in flight; waiting requesters hold req until gnt, nothing is queued.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int MULT_LATENCY = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] op_a,
  input  logic [NUM_REQ*DATA_W-1:0] op_b,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_product,
  output logic                      mul_enable,
  output logic [DATA_W-1:0]         mul_a,
  output logic [DATA_W-1:0]         mul_b,
  input  logic [DATA_W-1:0]         mul_product,
  output logic                      busy
);

  localparam int PW = idx_w(NUM_REQ);
  localparam int CW = idx_w(MULT_LATENCY + 1);

  logic [1:0]         state_q, state_d;
  logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] owner_q, owner_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic               mul_en_q, mul_en_d;
  logic [DATA_W-1:0]  mul_a_q, mul_a_d;
  logic [DATA_W-1:0]  mul_b_q, mul_b_d;
  logic [DATA_W-1:0]  rsp_product_q, rsp_product_d;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [PW-1:0]      pick_idx;
  logic               pick_any;
  logic [DATA_W-1:0]  win_a;
  logic [DATA_W-1:0]  win_b;

  rr_picker #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_picker (
    .req_i    (req),
    .ptr_i    (rr_ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  assign win_a = op_a[DATA_W*pick_idx +: DATA_W];
  assign win_b = op_b[DATA_W*pick_idx +: DATA_W];

  // Next-state: grant from IDLE, count out the multiplier latency, then respond to the owner.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    cnt_d         = cnt_q;
    gnt_d         = '0;
    owner_d       = owner_q;
    rsp_valid_d   = '0;
    mul_en_d      = 1'b0;
    mul_a_d       = mul_a_q;
    mul_b_d       = mul_b_q;
    rsp_product_d = rsp_product_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          gnt_d    = pick_onehot;
          owner_d  = pick_onehot;
          mul_a_d  = win_a;
          mul_b_d  = win_b;
          rr_ptr_d = (pick_idx == PW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
          cnt_d    = '0;
`ifdef MULT_ARB_ZERO_BYPASS_EN
          // A zero operand makes the product zero; skip the multiplier entirely.
          if (win_a == '0 || win_b == '0) begin
            state_d = ST_BYPASS;
          end else begin
            mul_en_d = 1'b1;
            state_d  = ST_WAIT;
          end
`else
          mul_en_d = 1'b1;
          state_d  = ST_WAIT;
`endif
        end
      end
      ST_WAIT: begin
        // Completion is purely counter-timed; the multiplier has no done flag.
        if (cnt_q == CW'(MULT_LATENCY)) begin
          rsp_product_d = mul_product;
          rsp_valid_d   = owner_q;
          state_d       = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef MULT_ARB_ZERO_BYPASS_EN
      ST_BYPASS: begin
        rsp_product_d = '0;
        rsp_valid_d   = owner_q;
        state_d       = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset drops any in-flight transaction without a response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= '0;
      cnt_q         <= '0;
      gnt_q         <= '0;
      owner_q       <= '0;
      rsp_valid_q   <= '0;
      mul_en_q      <= 1'b0;
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      rsp_product_q <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      cnt_q         <= cnt_d;
      gnt_q         <= gnt_d;
      owner_q       <= owner_d;
      rsp_valid_q   <= rsp_valid_d;
      mul_en_q      <= mul_en_d;
      mul_a_q       <= mul_a_d;
      mul_b_q       <= mul_b_d;
      rsp_product_q <= rsp_product_d;
    end
  end

  assign gnt         = gnt_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_product = rsp_product_q;
  assign mul_enable  = mul_en_q;
  assign mul_a       = mul_a_q;
  assign mul_b       = mul_b_q;
  assign busy        = (state_q != ST_IDLE);

endmodule
